// File: rtl/data_bus_port.sv
// Registered load/store bus master: one valid/ready transaction per request.
// Optional watchdog abort when DATA_BUS_TIMEOUT_EN is defined.
module data_bus_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_wstrobe,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_wstrobe,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("data_bus_port: TIMEOUT_CYCLES out of range 1..65535");
  end

  // Byte lane is carried by the strobes, so the low address bits drop out.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_address[1:0];

`ifdef DATA_BUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wd_cnt;
`endif

  assign stall = (state == S_WAIT) ||
                 (state == S_IDLE && req_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      bus_valid   <= 1'b0;
      bus_address <= '0;
      bus_wstrobe <= '0;
      bus_wdata   <= '0;
      rdata       <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef DATA_BUS_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            bus_address <= {req_address[31:2], 2'b00};
            bus_wstrobe <= req_store ? req_wstrobe : 4'b0000;
            bus_wdata   <= req_wdata;
            bus_valid   <= 1'b1;
            state       <= S_WAIT;
`ifdef DATA_BUS_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (bus_ready) begin
            rdata     <= bus_rdata;
            bus_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
`ifdef DATA_BUS_TIMEOUT_EN
          else if (wd_cnt == TMAX) begin
            rdata     <= '0;
            bus_valid <= 1'b0;
            done      <= 1'b1;
            error     <= 1'b1;
            state     <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_port.sv
// Directed bench for data_bus_port with a done/rdata/error scoreboard.
// Timeout cases run when DATA_BUS_TIMEOUT_EN is defined.
module tb_data_bus_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_store;
  logic [31:0] req_address;
  logic [3:0]  req_wstrobe;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        error;
  logic [31:0] rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_address;
  logic [3:0]  bus_wstrobe;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;

  always #5 clk = ~clk;

  data_bus_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_store(req_store),
    .req_address(req_address),
    .req_wstrobe(req_wstrobe),
    .req_wdata(req_wdata),
    .stall(stall),
    .done(done),
    .error(error),
    .rdata(rdata),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_address(bus_address),
    .bus_wstrobe(bus_wstrobe),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.error = e;
    exp_q.push_back(x);
    done_exp++;
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      exp_t x;
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_done: got done=1 expected no done");
      end else begin
        x = exp_q.pop_front();
        chk("sb_rdata", rdata, x.rdata);
        chk("sb_error", {31'd0, error}, {31'd0, x.error});
        chk("sb_stall_on_done", {31'd0, stall}, 32'd0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic request(input logic st, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    req_valid   = 1'b1;
    req_store   = st;
    req_address = a;
    req_wstrobe = s;
    req_wdata   = d;
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_store   = 1'b0;
    req_address = '0;
    req_wstrobe = '0;
    req_wdata   = '0;
    bus_ready   = 1'b0;
    bus_rdata   = '0;

    // Reset state
    mid();
    mid();
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus_address", bus_address, 32'd0);
    chk("rst_bus_wstrobe", {28'd0, bus_wstrobe}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Load, ready in cycle 1
    request(1'b0, 32'h0000_1003, 4'b1000, 32'h1111_2222);
    mid();
    chk("ld_stall_c0", {31'd0, stall}, 32'd1);
    next_cycle();
    req_valid   = 1'b0;
    req_address = 32'hFFFF_FFFF;
    bus_ready   = 1'b1;
    bus_rdata   = 32'hDEAD_BEEF;
    push(32'hDEAD_BEEF, 1'b0);
    mid();
    chk("ld_bus_valid_c1", {31'd0, bus_valid}, 32'd1);
    chk("ld_bus_address", bus_address, 32'h0000_1000);
    chk("ld_bus_wstrobe", {28'd0, bus_wstrobe}, 32'd0);
    chk("ld_stall_c1", {31'd0, stall}, 32'd1);
    chk("ld_done_c1", {31'd0, done}, 32'd0);
    next_cycle();
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    mid();
    chk("ld_done_c2", {31'd0, done}, 32'd1);
    chk("ld_bus_valid_c2", {31'd0, bus_valid}, 32'd0);
    next_cycle();
    mid();
    chk("ld_done_c3", {31'd0, done}, 32'd0);
    chk("ld_rdata_hold", rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Store, ready delayed to cycle 5
    request(1'b1, 32'h0000_2002, 4'b1100, 32'hABCD_ABCD);
    next_cycle();
    req_valid   = 1'b0;
    req_wdata   = 32'h0;
    req_wstrobe = 4'b0000;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        bus_ready = 1'b1;
        bus_rdata = 32'h1234_5678;
        push(32'h1234_5678, 1'b0);
      end
      mid();
      chk("st_bus_valid", {31'd0, bus_valid}, 32'd1);
      chk("st_bus_address", bus_address, 32'h0000_2000);
      chk("st_bus_wstrobe", {28'd0, bus_wstrobe}, 32'hC);
      chk("st_bus_wdata", bus_wdata, 32'hABCD_ABCD);
      chk("st_done_wait", {31'd0, done}, 32'd0);
      next_cycle();
    end
    bus_ready = 1'b0;
    mid();
    chk("st_done_c6", {31'd0, done}, 32'd1);
    chk("st_error_c6", {31'd0, error}, 32'd0);
    next_cycle();

    // Back-to-back with bus_ready held high
    bus_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      request(1'b0, 32'h0000_3000 + 32'(i), 4'b0000, 32'h0);
      bus_rdata = 32'hA000_0000 + 32'(i);
      if (i % 3 == 1) push(32'hA000_0000 + 32'(i), 1'b0);
      mid();
      chk("b2b_done", {31'd0, done}, {31'd0, (i % 3 == 2)});
      chk("b2b_bus_valid", {31'd0, bus_valid}, {31'd0, (i % 3 == 1)});
      chk("b2b_stall", {31'd0, stall}, {31'd0, (i % 3 != 2)});
      next_cycle();
    end
    req_valid = 1'b0;
    bus_ready = 1'b0;
    next_cycle();

    // Asynchronous reset in cycle 2 of WAIT
    request(1'b1, 32'h0000_4000, 4'b1111, 32'h5555_AAAA);
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    #2;
    chk("ar_bus_valid_pre", {31'd0, bus_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("ar_stall", {31'd0, stall}, 32'd0);
    chk("ar_rdata", rdata, 32'd0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("ar_no_done", {31'd0, done}, 32'd0);
      next_cycle();
    end

`ifdef DATA_BUS_TIMEOUT_EN
    // Watchdog expiry with no ready
    request(1'b0, 32'h0000_5004, 4'b0000, 32'h0);
    next_cycle();
    req_valid = 1'b0;
    bus_rdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) push(32'h0, 1'b1);
      mid();
      chk("to_bus_valid", {31'd0, bus_valid}, 32'd1);
      chk("to_done_wait", {31'd0, done}, 32'd0);
      next_cycle();
    end
    mid();
    chk("to_done_c6", {31'd0, done}, 32'd1);
    chk("to_error_c6", {31'd0, error}, 32'd1);
    chk("to_rdata_c6", rdata, 32'd0);
    chk("to_bus_valid_c6", {31'd0, bus_valid}, 32'd0);
    next_cycle();
    next_cycle();

    // Ready exactly in the expiry cycle wins
    request(1'b0, 32'h0000_6000, 4'b0000, 32'h0);
    next_cycle();
    req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin
        bus_ready = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
        push(32'h0BAD_F00D, 1'b0);
      end
      mid();
      chk("tx_bus_valid", {31'd0, bus_valid}, 32'd1);
      next_cycle();
    end
    bus_ready = 1'b0;
    mid();
    chk("tx_done_c6", {31'd0, done}, 32'd1);
    chk("tx_error_c6", {31'd0, error}, 32'd0);
    chk("tx_rdata_c6", rdata, 32'h0BAD_F00D);
    next_cycle();
`else
    // Without the watchdog a long wait never aborts
    request(1'b0, 32'h0000_5004, 4'b0000, 32'h0);
    next_cycle();
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) begin
        bus_ready = 1'b1;
        bus_rdata = 32'h55AA_55AA;
        push(32'h55AA_55AA, 1'b0);
      end
      mid();
      chk("nw_bus_valid", {31'd0, bus_valid}, 32'd1);
      chk("nw_done_wait", {31'd0, done}, 32'd0);
      next_cycle();
    end
    bus_ready = 1'b0;
    mid();
    chk("nw_done", {31'd0, done}, 32'd1);
    chk("nw_error", {31'd0, error}, 32'd0);
    next_cycle();
`endif

    next_cycle();
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("sb_done_count", 32'(done_seen), 32'(done_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
